video_frame_crc: RTL and testbench

- Parametrised, synthesisable frame-capture checker.
- Sits on the video pipeline output, after the colour stage and before the DAC/HDMI encoder.
- Computes a CRC-32 over every active pixel of each frame and counts frames.
- With geometry checking compiled in, also flags line/frame size mismatches.
- Replaces file-based frame grabbing with an on-chip signature for simulation and hardware self-test.

---
 rtl/video_pkg.sv | 15 +
 rtl/video_frame_crc_if.sv | 11 +
 rtl/video_crc32_step.sv | 23 ++
 rtl/video_frame_crc.sv | 167 ++++++++++++++++
 tb/tb_video_frame_crc.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared constants and state encoding for the video frame CRC checker.
package video_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/video_frame_crc_if.sv
// Video stream bundle: pixel-valid strobe, vertical sync and packed pixel data.
interface video_frame_crc_if #(
  parameter int DW = 24
);
  logic          vid_active;
  logic          vid_vsync;
  logic [DW-1:0] vid_dat;

  modport master (output vid_active, output vid_vsync, output vid_dat);
  modport slave  (input  vid_active, input  vid_vsync, input  vid_dat);
endinterface

// File: rtl/video_crc32_step.sv
// One-cycle CRC-32 advance over a DW-bit word, MSB first, unreflected.
module video_crc32_step
  import video_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic [31:0]   crc_i,
  input  logic [DW-1:0] data_i,
  output logic [31:0]   crc_o
);

  logic [31:0] acc;

  always_comb begin
    acc = crc_i;
    for (int i = DW - 1; i >= 0; i--) begin
      if (acc[31] ^ data_i[i]) acc = {acc[30:0], 1'b0} ^ CRC32_POLY;
      else                     acc = {acc[30:0], 1'b0};
    end
    crc_o = acc;
  end

endmodule

// File: rtl/video_frame_crc.sv
// Frame signature checker: CRC-32 over active pixels plus frame counter.
// Line/frame geometry checking is compiled in with VIDEO_FRAME_CRC_GEOM_CHECK_EN.
//
// state   | meaning
// IDLE    | capture disabled, running CRC and counters cleared
// ARM     | waiting for a vsync edge to start a frame
// CAPTURE | folding active pixels into the CRC
// DONE    | result published; back to ARM, or straight to CAPTURE after a vsync-ended frame
module video_frame_crc
  import video_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CCW    = 8,
  parameter int NCH    = 3,
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en_i,
  input  logic             en_i,
  video_frame_crc_if.slave vid,
  output logic [31:0]      crc_o,
  output logic             crc_vld_o,
  output logic [15:0]      frame_cnt_o,
  output logic             busy_o,
  output logic             err_line_o,
  output logic             err_frame_o
);

  localparam int          DW       = NCH * CCW;
  localparam logic [23:0] PIX_LAST = 24'(WIDTH * HEIGHT - 1);

  state_e      state_q;
  logic [31:0] crc_q, crc_step, crc_cur, crc_out_q;
  logic [23:0] pix_q;
  logic [15:0] fcnt_q;
  logic        vs_q, rearm_q, vld_q, busy_q, err_frame_q;
  logic        vs_edge, last_pix, geom_frame_bad;

  video_crc32_step #(.DW(DW)) u_step (
    .crc_i  (crc_q),
    .data_i (vid.vid_dat),
    .crc_o  (crc_step)
  );

  assign vs_edge  = (vid.vid_vsync == VS_POL) && (vs_q != VS_POL);
  assign crc_cur  = vid.vid_active ? crc_step : crc_q;
  assign last_pix = vid.vid_active && (pix_q == PIX_LAST);

`ifdef VIDEO_FRAME_CRC_GEOM_CHECK_EN
  logic [11:0] line_pix_q, line_cnt_q;
  logic        act_q, fall, err_line_q;

  assign fall           = act_q && !vid.vid_active;
  // The last line's falling edge arrives while in DONE, so fold it in here.
  assign geom_frame_bad = (line_cnt_q + {11'd0, fall}) != 12'(HEIGHT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q      <= 1'b0;
      line_pix_q <= '0;
      line_cnt_q <= '0;
      err_line_q <= 1'b0;
    end else if (clk_en_i) begin
      act_q <= vid.vid_active;
      if (en_i && fall && (line_pix_q != 12'(WIDTH)) &&
          (state_q == CAPTURE || state_q == DONE))
        err_line_q <= 1'b1;
      else if (en_i && state_q == IDLE)
        err_line_q <= 1'b0;
      if (en_i && state_q == CAPTURE) begin
        if (vid.vid_active) begin
          line_pix_q <= line_pix_q + 12'd1;
        end else if (fall) begin
          line_pix_q <= '0;
          line_cnt_q <= line_cnt_q + 12'd1;
        end
      end else begin
        line_pix_q <= '0;
        line_cnt_q <= '0;
      end
    end
  end

  assign err_line_o = err_line_q;
`else
  assign geom_frame_bad = 1'b0;
  assign err_line_o     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= '0;
      pix_q       <= '0;
      vs_q        <= VS_POL;
      rearm_q     <= 1'b0;
      crc_out_q   <= '0;
      vld_q       <= 1'b0;
      fcnt_q      <= '0;
      busy_q      <= 1'b0;
      err_frame_q <= 1'b0;
    end else if (clk_en_i) begin
      vs_q  <= vid.vid_vsync;
      vld_q <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        crc_q   <= '0;
        pix_q   <= '0;
        rearm_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            err_frame_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ARM;
          end
          ARM: begin
            if (vs_edge) begin
              crc_q   <= CRC32_INIT;
              pix_q   <= '0;
              state_q <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (vid.vid_active) begin
              crc_q <= crc_step;
              pix_q <= pix_q + 24'd1;
            end
            // Result is latched on entry to DONE so crc_vld follows the last pixel by one cycle.
            if (last_pix || vs_edge) begin
              if (!last_pix) err_frame_q <= 1'b1;
              rearm_q   <= vs_edge;
              crc_out_q <= crc_cur ^ CRC32_XOROUT;
              vld_q     <= 1'b1;
              fcnt_q    <= fcnt_q + 16'd1;
              busy_q    <= 1'b0;
              state_q   <= DONE;
            end
          end
          DONE: begin
            if (geom_frame_bad) err_frame_q <= 1'b1;
            rearm_q <= 1'b0;
            busy_q  <= 1'b1;
            if (rearm_q) begin
              crc_q   <= CRC32_INIT;
              pix_q   <= '0;
              state_q <= CAPTURE;
            end else begin
              state_q <= ARM;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign crc_o       = crc_out_q;
  assign crc_vld_o   = vld_q;
  assign frame_cnt_o = fcnt_q;
  assign busy_o      = busy_q;
  assign err_frame_o = err_frame_q;

endmodule

// File: tb/tb_video_frame_crc.sv
// Bench for video_frame_crc: byte-table CRC model, scoreboard of expected results per frame.
// Geometry is scaled down (32x24) to keep the run short; a second instance covers clk_en gating.
module tb_video_frame_crc;

  localparam int W1 = 32;
  localparam int H1 = 24;
  localparam int W2 = 8;
  localparam int H2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce1 = 1'b1, en1 = 1'b0;
  logic ce2 = 1'b0, en2 = 1'b0;

  logic [31:0] crc1, crc2;
  logic        vld1, vld2, busy1, busy2, el1, el2, ef1, ef2;
  logic [15:0] fc1, fc2;

  video_frame_crc_if #(.DW(24)) vif1 ();
  video_frame_crc_if #(.DW(8))  vif2 ();

  video_frame_crc #(.WIDTH(W1), .HEIGHT(H1), .CCW(8), .NCH(3), .VS_POL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clk_en_i(ce1), .en_i(en1), .vid(vif1),
    .crc_o(crc1), .crc_vld_o(vld1), .frame_cnt_o(fc1), .busy_o(busy1),
    .err_line_o(el1), .err_frame_o(ef1));

  video_frame_crc #(.WIDTH(W2), .HEIGHT(H2), .CCW(8), .NCH(1), .VS_POL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .clk_en_i(ce2), .en_i(en2), .vid(vif2),
    .crc_o(crc2), .crc_vld_o(vld2), .frame_cnt_o(fc2), .busy_o(busy2),
    .err_line_o(el2), .err_frame_o(ef2));

  always #5 clk = ~clk;

`ifdef VIDEO_FRAME_CRC_GEOM_CHECK_EN
  localparam logic GEOM = 1'b1;
`else
  localparam logic GEOM = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] crc_tab [256];
  logic [31:0] e1_crc[$], e2_crc[$];
  logic [15:0] e1_fc[$],  e2_fc[$];
  logic [15:0] mfc1 = 16'd0, mfc2 = 16'd0;
  logic [31:0] m_crc1 = 32'd0, m_crc2 = 32'd0;
  int          nq2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard byte-at-a-time table CRC (unreflected), used as the reference.
  function automatic logic [31:0] crc_bytes(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = {c[23:0], 8'h00} ^ crc_tab[c[31:24] ^ b[i]];
    return c ^ 32'hFFFF_FFFF;
  endfunction

  task automatic push1(input logic [31:0] c);
    mfc1 = mfc1 + 16'd1;
    e1_crc.push_back(c);
    e1_fc.push_back(mfc1);
  endtask

  task automatic drive1(input logic a, input logic vs, input logic [23:0] d);
    vif1.vid_active = a;
    vif1.vid_vsync  = vs;
    vif1.vid_dat    = d;
    @(posedge clk); #1;
  endtask

  // Pixel = {line[7:0], 16'h0}. bad_line gets one pixel fewer; abort_line drops en at its start.
  task automatic frame1(input int nlines, input int bad_line, input int abort_line, input bit exp);
    logic [7:0]  bq[$];
    logic [23:0] d;
    int          n;
    bit          full;
    full = (nlines == H1) && (bad_line < 0);
    drive1(1'b0, 1'b1, 24'h0);
    drive1(1'b0, 1'b1, 24'h0);
    repeat (3) drive1(1'b0, 1'b0, 24'h0);
    for (int l = 0; l < nlines; l++) begin
      if (l == abort_line) en1 = 1'b0;
      n = (l == bad_line) ? W1 - 1 : W1;
      for (int p = 0; p < n; p++) begin
        d = {8'(l), 16'h0000};
        bq.push_back(d[23:16]);
        bq.push_back(d[15:8]);
        bq.push_back(d[7:0]);
        if (exp && full && l == nlines - 1 && p == n - 1) push1(crc_bytes(bq));
        drive1(1'b1, 1'b0, d);
      end
      repeat (3) drive1(1'b0, 1'b0, 24'h0);
    end
    if (exp && !full) push1(crc_bytes(bq));
    repeat (4) drive1(1'b0, 1'b0, 24'h0);
  endtask

  task automatic en1_cycle();
    en1 = 1'b0;
    repeat (2) drive1(1'b0, 1'b0, 24'h0);
    en1 = 1'b1;
    drive1(1'b0, 1'b0, 24'h0);
  endtask

  // One clk_en-qualified step of DUT2: enable high for the first of three clocks.
  task automatic step2(input logic a, input logic vs, input logic [7:0] d);
    vif2.vid_active = a;
    vif2.vid_vsync  = vs;
    vif2.vid_dat    = d;
    ce2 = 1'b1;
    @(posedge clk); #1;
    ce2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic frame2();
    logic [7:0] bq[$];
    step2(1'b0, 1'b1, 8'h0);
    step2(1'b0, 1'b1, 8'h0);
    repeat (2) step2(1'b0, 1'b0, 8'h0);
    for (int l = 0; l < H2; l++) begin
      for (int p = 0; p < W2; p++) begin
        bq.push_back(8'h00);
        if (l == H2 - 1 && p == W2 - 1) begin
          mfc2 = mfc2 + 16'd1;
          e2_crc.push_back(crc_bytes(bq));
          e2_fc.push_back(mfc2);
        end
        step2(1'b1, 1'b0, 8'h00);
      end
      repeat (2) step2(1'b0, 1'b0, 8'h0);
    end
    repeat (3) step2(1'b0, 1'b0, 8'h0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (vld1) begin
        if (e1_crc.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL crc_vld1_unexpected: got pulse expected none");
        end else begin
          m_crc1 = e1_crc.pop_front();
          check("crc1", crc1, m_crc1);
          check("frame_cnt1", {16'd0, fc1}, {16'd0, e1_fc.pop_front()});
        end
      end else begin
        check("crc1_hold", crc1, m_crc1);
      end
      if (ce2 && vld2) begin
        nq2++;
        if (e2_crc.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL crc_vld2_unexpected: got pulse expected none");
        end else begin
          m_crc2 = e2_crc.pop_front();
          check("crc2", crc2, m_crc2);
          check("frame_cnt2", {16'd0, fc2}, {16'd0, e2_fc.pop_front()});
        end
      end else if (!vld2) begin
        check("crc2_hold", crc2, m_crc2);
      end
    end
  end

  initial begin
    logic [7:0]  pin[$];
    logic [31:0] first_crc;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i) << 24;
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      crc_tab[i] = c;
    end
    for (int i = 0; i < 9; i++) pin.push_back(8'h31 + 8'(i));
    check("model_check_123456789", crc_bytes(pin), 32'hFC89_1918);
    pin.delete();
    check("model_empty", crc_bytes(pin), 32'h0000_0000);

    vif1.vid_active = 1'b0; vif1.vid_vsync = 1'b0; vif1.vid_dat = '0;
    vif2.vid_active = 1'b0; vif2.vid_vsync = 1'b0; vif2.vid_dat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_crc", crc1, 32'h0);
    check("rst_crc_vld", {31'd0, vld1}, 32'd0);
    check("rst_frame_cnt", {16'd0, fc1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_err_line", {31'd0, el1}, 32'd0);
    check("rst_err_frame", {31'd0, ef1}, 32'd0);
    @(posedge clk); #1;

    en1 = 1'b1;
    drive1(1'b0, 1'b0, 24'h0);
    check("busy_armed", {31'd0, busy1}, 32'd1);

    frame1(H1, -1, -1, 1'b1);
    first_crc = m_crc1;
    check("frame1_cnt", {16'd0, fc1}, 32'd1);
    check("frame1_err_line", {31'd0, el1}, 32'd0);
    check("frame1_err_frame", {31'd0, ef1}, 32'd0);

    frame1(H1, -1, -1, 1'b1);
    check("frame2_same_crc", crc1, first_crc);
    check("frame2_cnt", {16'd0, fc1}, 32'd2);

    frame1(10, -1, -1, 1'b1);
    frame1(H1, -1, -1, 1'b1);
    check("short_err_frame", {31'd0, ef1}, 32'd1);
    check("short_err_line", {31'd0, el1}, 32'd0);
    check("short_cnt", {16'd0, fc1}, 32'd4);

    en1_cycle();
    check("clr_err_frame", {31'd0, ef1}, 32'd0);
    frame1(H1, 5, -1, 1'b1);
    frame1(H1, -1, -1, 1'b1);
    check("badline_err_line", {31'd0, el1}, {31'd0, GEOM});
    check("badline_err_frame", {31'd0, ef1}, 32'd1);

    frame1(H1, -1, 3, 1'b0);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_err_frame_sticky", {31'd0, ef1}, 32'd1);
    en1 = 1'b1;
    drive1(1'b0, 1'b0, 24'h0);
    check("reen_err_frame", {31'd0, ef1}, 32'd0);
    check("reen_err_line", {31'd0, el1}, 32'd0);
    check("reen_busy", {31'd0, busy1}, 32'd1);
    frame1(H1, -1, -1, 1'b1);
    check("after_abort_cnt", {16'd0, fc1}, 32'd7);
    repeat (5) drive1(1'b0, 1'b0, 24'h0);
    check("pending1", 32'(e1_crc.size()), 32'd0);

    en2 = 1'b1;
    repeat (2) step2(1'b0, 1'b0, 8'h0);
    frame2();
    frame2();
    repeat (3) step2(1'b0, 1'b0, 8'h0);
    check("pending2", 32'(e2_crc.size()), 32'd0);
    check("vld2_qualified_cycles", 32'(nq2), 32'd2);
    check("frame_cnt2_final", {16'd0, fc2}, 32'd2);
    check("err_frame2", {31'd0, ef2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
